// File: rtl/hazard_ctrl_v.sv
// Hazard control for a 5-stage pipeline: EX-stage operand forwarding,
// load-use / RAW stall detection, multi-cycle data-memory freeze FSM,
// branch flush control and saturating stall/flush performance counters.
module hazard_ctrl_v #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] idex_rs1,
    input  logic [REG_AW-1:0] idex_rs2,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_regWrite,
    input  logic              idex_memRead,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regWrite,
    input  logic              exmem_memRead,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regWrite,
    input  logic              branch_taken,
    output logic [1:0]        forwA,
    output logic [1:0]        forwB,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              freeze,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic              mem_wait
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // First WAIT-cycle count: the RUN trigger cycle already freezes once,
    // so WAIT freezes MEM_LAT-2 more cycles before its release cycle.
    localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
    localparam bit         USE_WAIT  = (MEM_LAT > 1);
    localparam bit         USE_FWD   = (FWD_EN != 0);

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic              freeze_raw;
    logic              raw_hz;
    logic              idex_used_match;
    logic              exmem_used_match;

    // A "used match": nonzero destination that the ID instruction actually reads.
    assign idex_used_match  = (idex_rd != '0) &&
                              ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                               (id_use_rs2 && (id_rs2 == idex_rd)));
    assign exmem_used_match = (exmem_rd != '0) &&
                              ((id_use_rs1 && (id_rs1 == exmem_rd)) ||
                               (id_use_rs2 && (id_rs2 == exmem_rd)));

    // With forwarding only a load in EX is unresolvable; without it any pending
    // writer in EX or MEM stalls (MEM/WB is covered by write-before-read).
    assign raw_hz = USE_FWD ? (idex_memRead && idex_used_match)
                            : ((idex_regWrite && idex_used_match) ||
                               (exmem_regWrite && exmem_used_match));

    // Operand forwarding select; EX/MEM result is newer so it beats MEM/WB.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        forwA = 2'b00;
        forwB = 2'b00;
        if (!rst && USE_FWD) begin
            if (exmem_regWrite && !exmem_memRead && (exmem_rd != '0) && (exmem_rd == idex_rs1))
                forwA = 2'b01;
            else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == idex_rs1))
                forwA = 2'b10;

            if (exmem_regWrite && !exmem_memRead && (exmem_rd != '0) && (exmem_rd == idex_rs2))
                forwB = 2'b01;
            else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == idex_rs2))
                forwB = 2'b10;
        end
    end

    // Freeze FSM next-state: RUN triggers on a load in MEM, WAIT counts down
    // and spends one unfrozen release cycle while the load leaves EX/MEM.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze_raw = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exmem_memRead && USE_WAIT) begin
                    freeze_raw = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q != 4'd0) begin
                    freeze_raw = 1'b1;
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Pipeline control priority: reset, then freeze, then branch flush, then RAW stall.
    always_comb begin
        freeze     = 1'b0;
        stall_id   = 1'b0;
        bubble_ex  = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (!rst) begin
            if (freeze_raw) begin
                freeze = 1'b1;
            end else if (branch_taken) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (raw_hz) begin
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    // Saturating performance counter next values.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((freeze || stall_id) && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 1'b1;
        if (flush_ifid && (flush_count_q != '1))
            flush_count_d = flush_count_q + 1'b1;
    end

    // State, wait counter and performance counters with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= 4'd0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign mem_wait     = (state_q == ST_WAIT);

endmodule

// File: tb/tb_hazard_ctrl_v.sv
// Directed bench for hazard_ctrl_v. Three 16-bit-counter instances share the
// stimulus: [0] FWD_EN=1 MEM_LAT=4, [1] FWD_EN=0 MEM_LAT=1, [2] FWD_EN=1
// MEM_LAT=8; a fourth instance u_sat has CNT_W=2 for saturation.
module tb_hazard_ctrl_v;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic       id_use_rs1, id_use_rs2, idex_regWrite, idex_memRead;
    logic       exmem_regWrite, exmem_memRead, memwb_regWrite, branch_taken;

    logic [1:0]  fa [3];
    logic [1:0]  fb [3];
    logic        stall [3];
    logic        bubble [3];
    logic        frz [3];
    logic        fl_ifid [3];
    logic        fl_idex [3];
    logic [15:0] scnt [3];
    logic [15:0] fcnt [3];
    logic        mwait [3];

    logic [1:0]  s_fa, s_fb;
    logic        s_stall, s_bubble, s_frz, s_fl_ifid, s_fl_idex, s_mwait;
    logic [1:0]  s_scnt, s_fcnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        hazard_ctrl_v #(
            .REG_AW (5),
            .MEM_LAT((g == 0) ? 4 : ((g == 2) ? 8 : 1)),
            .FWD_EN ((g == 1) ? 0 : 1),
            .CNT_W  (16)
        ) u_dut (
            .clk(clk), .rst(rst),
            .id_rs1(id_rs1), .id_rs2(id_rs2),
            .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
            .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
            .idex_regWrite(idex_regWrite), .idex_memRead(idex_memRead),
            .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite), .exmem_memRead(exmem_memRead),
            .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite),
            .branch_taken(branch_taken),
            .forwA(fa[g]), .forwB(fb[g]),
            .stall_id(stall[g]), .bubble_ex(bubble[g]), .freeze(frz[g]),
            .flush_ifid(fl_ifid[g]), .flush_idex(fl_idex[g]),
            .stall_cycles(scnt[g]), .flush_count(fcnt[g]),
            .mem_wait(mwait[g])
        );
    end

    hazard_ctrl_v #(
        .REG_AW(5), .MEM_LAT(1), .FWD_EN(1), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_regWrite(idex_regWrite), .idex_memRead(idex_memRead),
        .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite), .exmem_memRead(exmem_memRead),
        .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite),
        .branch_taken(branch_taken),
        .forwA(s_fa), .forwB(s_fb),
        .stall_id(s_stall), .bubble_ex(s_bubble), .freeze(s_frz),
        .flush_ifid(s_fl_ifid), .flush_idex(s_fl_idex),
        .stall_cycles(s_scnt), .flush_count(s_fcnt),
        .mem_wait(s_mwait)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
        idex_regWrite = 1'b0; idex_memRead = 1'b0;
        exmem_rd = '0; exmem_regWrite = 1'b0; exmem_memRead = 1'b0;
        memwb_rd = '0; memwb_regWrite = 1'b0; branch_taken = 1'b0;
    endtask

    // Advance one clock; inputs are then changed and outputs sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        step();

        // Reset forces controls and forwarding off even with active hazards.
        exmem_rd = 5'd5; exmem_regWrite = 1'b1; idex_rs1 = 5'd5;
        exmem_memRead = 1'b1; branch_taken = 1'b1;
        #1;
        check("rst_forwA",  32'(fa[0]), 32'd0);
        check("rst_freeze", 32'(frz[0]), 32'd0);
        check("rst_flush",  32'(fl_ifid[0]), 32'd0);
        step();
        check("rst_stallcnt", 32'(scnt[0]), 32'd0);
        check("rst_flushcnt", 32'(fcnt[0]), 32'd0);
        check("rst_memwait",  32'(mwait[0]), 32'd0);
        do_reset();

        // Forwarding: EX/MEM over MEM/WB, then MEM/WB alone, then loads in MEM.
        exmem_rd = 5'd5; exmem_regWrite = 1'b1; idex_rs1 = 5'd5;
        memwb_rd = 5'd5; memwb_regWrite = 1'b1;
        #1;
        check("fwdA_exmem",   32'(fa[0]), 32'd1);
        check("fwdB_none",    32'(fb[0]), 32'd0);
        check("fwd0_forwA",   32'(fa[1]), 32'd0);
        exmem_rd = 5'd0;
        #1;
        check("fwdA_memwb",   32'(fa[0]), 32'd2);
        idex_rs2 = 5'd5;
        #1;
        check("fwdB_memwb",   32'(fb[0]), 32'd2);
        exmem_rd = 5'd5; exmem_memRead = 1'b1;
        #1;
        check("fwdA_load_skip", 32'(fa[0]), 32'd2);
        clear_inputs();
        #1;

        // Load-use: one stall cycle, then the bubble clears it.
        idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_rd = 5'd7;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        check("lu_stall",  32'(stall[0]), 32'd1);
        check("lu_bubble", 32'(bubble[0]), 32'd1);
        step();
        idex_memRead = 1'b0; idex_regWrite = 1'b0; idex_rd = 5'd0;
        #1;
        check("lu_released", 32'(stall[0]), 32'd0);
        check("lu_stallcnt", 32'(scnt[0]), 32'd1);
        idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_rd = 5'd7; id_use_rs2 = 1'b0;
        #1;
        check("lu_unused_rs2", 32'(stall[0]), 32'd0);
        do_reset();

        // Branch beats a coincident load-use hazard.
        idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_rd = 5'd7;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1; branch_taken = 1'b1;
        #1;
        check("br_flush_ifid", 32'(fl_ifid[0]), 32'd1);
        check("br_flush_idex", 32'(fl_idex[0]), 32'd1);
        check("br_no_stall",   32'(stall[0]), 32'd0);
        check("br_no_bubble",  32'(bubble[0]), 32'd0);
        step();
        check("br_flushcnt", 32'(fcnt[0]), 32'd1);
        check("br_stallcnt", 32'(scnt[0]), 32'd0);
        do_reset();

        // MEM_LAT=4 freeze: 3 frozen cycles, then release; branch waits for release.
        exmem_memRead = 1'b1;
        #1;
        check("fz_c1_freeze",  32'(frz[0]), 32'd1);
        check("fz_c1_memwait", 32'(mwait[0]), 32'd0);
        step();
        branch_taken = 1'b1;
        #1;
        check("fz_c2_freeze",  32'(frz[0]), 32'd1);
        check("fz_c2_memwait", 32'(mwait[0]), 32'd1);
        check("fz_c2_noflush", 32'(fl_ifid[0]), 32'd0);
        step();
        check("fz_c3_freeze",  32'(frz[0]), 32'd1);
        check("fz_c3_memwait", 32'(mwait[0]), 32'd1);
        step();
        check("fz_c4_release", 32'(frz[0]), 32'd0);
        check("fz_c4_memwait", 32'(mwait[0]), 32'd1);
        check("fz_c4_flush",   32'(fl_ifid[0]), 32'd1);
        step();
        exmem_memRead = 1'b0; branch_taken = 1'b0;
        #1;
        check("fz_c5_freeze",   32'(frz[0]), 32'd0);
        check("fz_c5_memwait",  32'(mwait[0]), 32'd0);
        check("fz_stallcnt",    32'(scnt[0]), 32'd3);
        check("fz_flushcnt",    32'(fcnt[0]), 32'd1);
        check("lat1_no_freeze", 32'(frz[1]), 32'd0);
        do_reset();

        // FWD_EN=0: every pending writer stalls, forwarding stays off.
        exmem_regWrite = 1'b1; exmem_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        idex_rs1 = 5'd3;
        #1;
        check("nf_exmem_stall", 32'(stall[1]), 32'd1);
        check("nf_forwA",       32'(fa[1]), 32'd0);
        check("f1_forwA",       32'(fa[0]), 32'd1);
        check("f1_no_stall",    32'(stall[0]), 32'd0);
        exmem_regWrite = 1'b0; memwb_rd = 5'd3; memwb_regWrite = 1'b1;
        #1;
        check("nf_memwb_nostall", 32'(stall[1]), 32'd0);
        idex_regWrite = 1'b1; idex_rd = 5'd3;
        #1;
        check("nf_idex_stall", 32'(stall[1]), 32'd1);
        check("nf_idex_bubble", 32'(bubble[1]), 32'd1);
        idex_rd = 5'd0; id_rs1 = 5'd0;
        #1;
        check("nf_rd0_nostall", 32'(stall[1]), 32'd0);
        do_reset();

        // MEM_LAT=8: reset on the 3rd frozen cycle leaves nothing behind.
        exmem_memRead = 1'b1;
        step();
        step();
        check("r8_c3_freeze",  32'(frz[2]), 32'd1);
        check("r8_c3_memwait", 32'(mwait[2]), 32'd1);
        check("r8_c3_stallcnt", 32'(scnt[2]), 32'd2);
        rst = 1'b1;
        #1;
        check("r8_rst_freeze", 32'(frz[2]), 32'd0);
        step();
        rst = 1'b0; exmem_memRead = 1'b0;
        #1;
        check("r8_post_freeze",   32'(frz[2]), 32'd0);
        check("r8_post_memwait",  32'(mwait[2]), 32'd0);
        check("r8_post_stallcnt", 32'(scnt[2]), 32'd0);
        step();
        check("r8_next_freeze",   32'(frz[2]), 32'd0);
        do_reset();

        // CNT_W=2: five stall cycles saturate at 3.
        idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_rd = 5'd9;
        id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("sat_at3", 32'(s_scnt), 32'd3);
        for (int i = 0; i < 2; i++) step();
        check("sat_hold", 32'(s_scnt), 32'd3);
        check("wide_cnt5", 32'(scnt[0]), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_v.md
Name: hazard_ctrl_v

Overview:
- Parametrised successor to the 5-stage hazard detection unit.
- Combinational EX-stage operand forwarding, plus load-use and no-forwarding RAW stalls.
- Sequential freeze controller for multi-cycle data memory (MEM_LAT), branch-flush control, and saturating stall/flush performance counters.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their hold/flush/bubble controls.

Parameters:
- REG_AW, 5, register-address width (register count = 2^REG_AW); address 0 is hardwired zero.
- MEM_LAT, 1, data-memory latency in cycles for loads; valid range 1..16.
- FWD_EN, 1, 1 = forwarding enabled; 0 = no forwarding, stall on every RAW hazard.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- idex_rs1, idex_rs2, idex_rd  in  REG_AW  ID/EX register fields
- idex_regWrite, idex_memRead  in  1  ID/EX controls
- exmem_rd  in  REG_AW;  exmem_regWrite, exmem_memRead  in  1  EX/MEM fields
- memwb_rd  in  REG_AW;  memwb_regWrite  in  1  MEM/WB fields
- branch_taken  in  1  EX-stage redirect
- forwA, forwB  out  2  00 = register file, 01 = EX/MEM, 10 = MEM/WB
- stall_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load ID/EX with a NOP
- freeze  out  1  hold PC and all four pipeline registers
- flush_ifid, flush_idex  out  1  squash the respective register
- stall_cycles, flush_count  out  CNT_W  performance counters
- mem_wait  out  1  FSM is in WAIT

Behaviour:
- Single clock domain; reset is synchronous and active-high: on a rising clk edge with rst=1, state=RUN, wait_cnt=0, both counters=0.
- While rst=1, all control outputs (stall_id, bubble_ex, freeze, flush_*) are forced to 0 and forwA/forwB are forced to 00.
- Forwarding (combinational), applied independently per operand:
  - EX/MEM wins over MEM/WB.
  - EX/MEM match requires exmem_regWrite, exmem_rd≠0, exmem_rd==idex_rsX and exmem_memRead=0.
  - MEM/WB match requires memwb_regWrite, memwb_rd≠0, memwb_rd==idex_rsX.
  - FWD_EN=0: forwA=forwB=00 always.
- RAW stall, raw_hz (combinational):
  - A "used match" means rd≠0 and rd equals a used id_rsX.
  - FWD_EN=1: raw_hz = idex_memRead and a used match on idex_rd.
  - FWD_EN=0: raw_hz = (idex_regWrite and a used match on idex_rd) or (exmem_regWrite and a used match on exmem_rd). MEM/WB is never a hazard because the register file is write-before-read.
- Memory freeze FSM, states RUN and WAIT:
  - RUN, exmem_memRead=1 and MEM_LAT>1: freeze=1 this cycle; next state WAIT with wait_cnt=MEM_LAT-2.
  - WAIT, wait_cnt>0: freeze=1, decrement wait_cnt.
  - WAIT, wait_cnt=0: freeze=0 (release cycle); next state RUN.
  - Total freeze per load = MEM_LAT-1 cycles. The load leaves EX/MEM on the release cycle, so it does not retrigger.
  - MEM_LAT=1: FSM never leaves RUN; freeze is constant 0.
  - mem_wait = (state==WAIT).
- Priority, highest first:
  1. rst.
  2. freeze=1 forces stall_id, bubble_ex, flush_ifid and flush_idex to 0; branch_taken is ignored and re-evaluated after release.
  3. branch_taken=1 sets flush_ifid=1 and flush_idex=1, and stall_id=0, bubble_ex=0 (the hazardous ID instruction is squashed).
  4. raw_hz=1 sets stall_id=1 and bubble_ex=1.
- Counters:
  - stall_cycles increments on every cycle with freeze or stall_id.
  - flush_count increments on every cycle with flush_ifid.
  - Both saturate at 2^CNT_W-1.
- Reset mid-WAIT: the FSM returns to RUN the following cycle and no residual freeze occurs.

Test Plan:
- FWD_EN=1: exmem_rd=5, exmem_regWrite=1, idex_rs1=5, and memwb_rd=5 with regWrite=1 -> forwA=01. Same again with exmem_rd=0 -> forwA=10.
- idex_memRead=1, idex_rd=7, id_rs2=7, id_use_rs2=1 -> stall_id=1, bubble_ex=1 for exactly one cycle. Same with id_use_rs2=0 -> no stall.
- MEM_LAT=4, exmem_memRead pulses with the load held -> freeze=1 for exactly 3 cycles, mem_wait=1 for cycles 2–4, stall_cycles=3.
- branch_taken=1 coincident with a load-use hazard -> flush_ifid=flush_idex=1, stall_id=0, flush_count+1. Same during freeze -> no flush.
- FWD_EN=0: exmem_regWrite=1, exmem_rd=3, id_rs1=3 used -> stall_id=1 and forwA=00. A memwb_rd=3 match alone -> no stall.
- MEM_LAT=8, rst asserted on the 3rd frozen cycle -> next cycle freeze=0, mem_wait=0, counters=0. CNT_W=2 with 5 stalls -> stall_cycles holds at 3.
